// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register and optional one-entry
// skid buffer. Build option: FETCH_SKID_BUFFER_EN (undefined -> no buffer).
module fetch_stage #(
  parameter int unsigned          DATA_BITS = 32,
  parameter logic [DATA_BITS-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned          PC_STEP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [DATA_BITS-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [DATA_BITS-1:0] imem_rdata,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [DATA_BITS-1:0] redirect_pc,
  output logic [DATA_BITS-1:0] if_word,
  output logic [DATA_BITS-1:0] if_pc,
  output logic [DATA_BITS-1:0] if_pc_inc,
  output logic                 if_valid
);

  localparam logic [DATA_BITS-1:0] STEP = DATA_BITS'(PC_STEP);

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   pc_q, pc_d;
  logic [DATA_BITS-1:0]   word_q, word_d;
  logic [DATA_BITS-1:0]   ifpc_q, ifpc_d;
  logic [DATA_BITS-1:0]   ifinc_q, ifinc_d;
  logic                   valid_q, valid_d;
  logic [DATA_BITS-1:0]   pc_next;

`ifdef FETCH_SKID_BUFFER_EN
  logic [DATA_BITS-1:0]   skid_q, skid_d;
`endif

  // Wraps modulo 2^DATA_BITS by construction of the vector width.
  assign pc_next = pc_q + STEP;

  // Next-state: redirect beats stall beats ack.
  // HELD doubles as the skid-buffer valid flag, so leaving HELD invalidates it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    word_d  = word_q;
    ifpc_d  = ifpc_q;
    ifinc_d = ifinc_q;
    valid_d = valid_q;
`ifdef FETCH_SKID_BUFFER_EN
    skid_d  = skid_q;
`endif
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      word_d  = '0;
      state_d = FETCH;
    end else if (stall) begin
`ifdef FETCH_SKID_BUFFER_EN
      if ((state_q == FETCH) && imem_ack) begin
        skid_d  = imem_rdata;
        state_d = HELD;
      end
`endif
    end else if (state_q == HELD) begin
`ifdef FETCH_SKID_BUFFER_EN
      word_d  = skid_q;
`else
      word_d  = '0;
`endif
      ifpc_d  = pc_q;
      ifinc_d = pc_next;
      valid_d = 1'b1;
      pc_d    = pc_next;
      state_d = FETCH;
    end else if (imem_ack) begin
      word_d  = imem_rdata;
      ifpc_d  = pc_q;
      ifinc_d = pc_next;
      valid_d = 1'b1;
      pc_d    = pc_next;
    end else begin
      valid_d = 1'b0;
      word_d  = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      word_q  <= '0;
      ifpc_q  <= '0;
      ifinc_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_SKID_BUFFER_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      ifpc_q  <= ifpc_d;
      ifinc_q <= ifinc_d;
      valid_q <= valid_d;
`ifdef FETCH_SKID_BUFFER_EN
      skid_q  <= skid_d;
`endif
    end
  end

  // Request is suppressed combinationally while reset is held.
  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign if_word   = valid_q ? word_q : '0;
  assign if_pc     = ifpc_q;
  assign if_pc_inc = ifinc_q;
  assign if_valid  = valid_q;

endmodule
